// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ps2_pkg
// Brief   : Shared constants, state encodings and byte selection for the PS/2
//           scan-code transmitter.
// Revision: 1.0 - initial release
// ============================================================================
package ps2_pkg;

    localparam logic [7:0] PS2_BREAK_PREFIX = 8'hF0;
    localparam logic [7:0] PS2_EXT_PREFIX   = 8'hE0;
    localparam int         PS2_FRAME_BITS   = 11;

    typedef enum logic [1:0] {
        SEQ_IDLE = 2'd0,
        SEQ_SEND = 2'd1,
        SEQ_GAP  = 2'd2
    } seq_state_t;

    typedef enum logic [2:0] {
        FRM_IDLE  = 3'd0,
        FRM_SHIFT = 3'd1,
        FRM_WAIT  = 3'd2,
        FRM_ABORT = 3'd3,
        FRM_HOLD  = 3'd4
    } frm_state_t;

    // Next byte of an event given the prefixes still outstanding.
    function automatic logic [7:0] ps2_next_byte(input logic       ext,
                                                 input logic       brk,
                                                 input logic [7:0] code);
        if (ext)
            return PS2_EXT_PREFIX;
        else if (brk)
            return PS2_BREAK_PREFIX;
        return code;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_frame_tx.sv
`default_nettype none
// ============================================================================
// Module  : ps2_frame_tx
// Brief   : One-byte PS/2 device frame serialiser (start, 8 data, odd parity,
//           stop). Optional host-inhibit handling under PS2_TX_INHIBIT_EN.
// Revision: 1.0 - initial release
// ============================================================================
module ps2_frame_tx
    import ps2_pkg::*;
#(
    parameter int HALF_PERIOD = 4000,
    parameter int GAP_HALVES  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data_byte,
`ifdef PS2_TX_INHIBIT_EN
    input  logic       ps2_clk_in,
`endif
    output logic       done,
    output logic       ps2_clk,
    output logic       ps2_data
);

    localparam int            CW        = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_PERIOD - 1);
    localparam logic [3:0]    BIT_LAST  = 4'(PS2_FRAME_BITS - 1);

    frm_state_t    r_state, w_state;
    logic [CW-1:0] r_cnt, w_cnt;
    logic [3:0]    r_bit, w_bit;
    logic          r_low, w_low;
    logic          r_clk, w_clk;
    logic          r_data, w_data;
    logic [7:0]    r_byte, w_byte;
    logic          w_begin;
    logic          w_half_end;
    logic [3:0]    w_bit_inc;
    logic [10:0]   w_frame;

`ifdef PS2_TX_INHIBIT_EN
    localparam int            HW          = (GAP_HALVES > 1) ? $clog2(GAP_HALVES) : 1;
    localparam logic [HW-1:0] HALVES_LAST = HW'(GAP_HALVES - 1);
    logic [HW-1:0] r_halves, w_halves;
`endif

    assign w_half_end = (r_cnt == HALF_LAST);
    assign w_bit_inc  = r_bit + 4'd1;
    assign w_frame    = {1'b1, ~^r_byte, r_byte, 1'b0};

    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_bit   = r_bit;
        w_low   = r_low;
        w_clk   = r_clk;
        w_data  = r_data;
        w_byte  = r_byte;
        w_begin = 1'b0;
        done    = 1'b0;
`ifdef PS2_TX_INHIBIT_EN
        w_halves = r_halves;
`endif
        case (r_state)
            FRM_IDLE: begin
                w_clk  = 1'b1;
                w_data = 1'b1;
                if (start) begin
                    w_byte = data_byte;
`ifdef PS2_TX_INHIBIT_EN
                    if (ps2_clk_in)
                        w_begin = 1'b1;
                    else
                        w_state = FRM_WAIT;
`else
                    w_begin = 1'b1;
`endif
                end
            end
            FRM_SHIFT: begin
                w_cnt = w_half_end ? '0 : r_cnt + 1'b1;
`ifdef PS2_TX_INHIBIT_EN
                // Host pulling the clock low while we drive it high wins,
                // except once the stop bit is on the line.
                if (!r_low && !ps2_clk_in && (r_bit != BIT_LAST)) begin
                    w_state = FRM_ABORT;
                    w_clk   = 1'b1;
                    w_data  = 1'b1;
                end else
`endif
                if (w_half_end) begin
                    if (!r_low) begin
                        w_low = 1'b1;
                        w_clk = 1'b0;
                    end else begin
                        w_low = 1'b0;
                        w_clk = 1'b1;
                        if (r_bit == BIT_LAST) begin
                            done    = 1'b1;
                            w_state = FRM_IDLE;
                            w_data  = 1'b1;
                        end else begin
                            w_bit  = w_bit_inc;
                            w_data = w_frame[w_bit_inc];
                        end
                    end
                end
            end
`ifdef PS2_TX_INHIBIT_EN
            FRM_WAIT: begin
                w_clk  = 1'b1;
                w_data = 1'b1;
                if (ps2_clk_in)
                    w_begin = 1'b1;
            end
            FRM_ABORT: begin
                w_clk  = 1'b1;
                w_data = 1'b1;
                if (ps2_clk_in) begin
                    w_state  = FRM_HOLD;
                    w_cnt    = '0;
                    w_halves = '0;
                end
            end
            FRM_HOLD: begin
                w_clk  = 1'b1;
                w_data = 1'b1;
                w_cnt  = w_half_end ? '0 : r_cnt + 1'b1;
                if (w_half_end) begin
                    if (r_halves == HALVES_LAST) begin
                        if (ps2_clk_in)
                            w_begin = 1'b1;
                        else
                            w_state = FRM_ABORT;
                    end else begin
                        w_halves = r_halves + 1'b1;
                    end
                end
            end
`endif
            default: begin
                w_state = FRM_IDLE;
                w_clk   = 1'b1;
                w_data  = 1'b1;
            end
        endcase

        // Start bit goes out with the clock high, one cycle after the begin.
        if (w_begin) begin
            w_state = FRM_SHIFT;
            w_cnt   = '0;
            w_bit   = '0;
            w_low   = 1'b0;
            w_clk   = 1'b1;
            w_data  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FRM_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_low   <= 1'b0;
            r_clk   <= 1'b1;
            r_data  <= 1'b1;
            r_byte  <= '0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_bit   <= w_bit;
            r_low   <= w_low;
            r_clk   <= w_clk;
            r_data  <= w_data;
            r_byte  <= w_byte;
        end
    end

`ifdef PS2_TX_INHIBIT_EN
    always_ff @(posedge clk) begin
        if (rst)
            r_halves <= '0;
        else
            r_halves <= w_halves;
    end
`endif

    assign ps2_clk  = r_clk;
    assign ps2_data = r_data;

endmodule
`default_nettype wire

// File: rtl/ps2_scancode_tx.sv
`default_nettype none
// ============================================================================
// Module  : ps2_scancode_tx
// Brief   : PS/2 keyboard-side transmitter: one key event -> E0/F0/code frames.
//           Define PS2_TX_INHIBIT_EN to add ps2_clk_in host-inhibit support.
// Revision: 1.0 - initial release
// ============================================================================
module ps2_scancode_tx
    import ps2_pkg::*;
#(
    parameter int HALF_PERIOD = 4000,
    parameter int GAP_HALVES  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [7:0] key_code,
    input  logic       key_break,
    input  logic       key_ext,
`ifdef PS2_TX_INHIBIT_EN
    input  logic       ps2_clk_in,
`endif
    output logic       key_ready,
    output logic       busy,
    output logic       ps2_clk,
    output logic       ps2_data
);

    localparam int            GAP_CYCLES = GAP_HALVES * HALF_PERIOD;
    localparam int            GW         = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_CYCLES - 1);

    seq_state_t    r_state, w_state;
    logic [GW-1:0] r_gap_cnt, w_gap_cnt;
    logic [7:0]    r_code, w_code;
    logic          r_ext, w_ext;
    logic          r_brk, w_brk;
    logic          r_last, w_last;
    logic          w_accept;
    logic          w_frame_start;
    logic [7:0]    w_frame_byte;
    logic          w_frame_done;

    assign key_ready = (r_state == SEQ_IDLE);
    assign busy      = ~key_ready;
    assign w_accept  = key_valid && key_ready;

    // r_ext / r_brk track prefixes still to send; r_last marks the code byte gone.
    always_comb begin
        w_state       = r_state;
        w_gap_cnt     = r_gap_cnt;
        w_code        = r_code;
        w_ext         = r_ext;
        w_brk         = r_brk;
        w_last        = r_last;
        w_frame_start = 1'b0;
        w_frame_byte  = ps2_next_byte(r_ext, r_brk, r_code);
        case (r_state)
            SEQ_IDLE: begin
                if (w_accept) begin
                    w_code        = key_code;
                    w_ext         = key_ext;
                    w_brk         = key_break;
                    w_last        = 1'b0;
                    w_frame_start = 1'b1;
                    w_frame_byte  = ps2_next_byte(key_ext, key_break, key_code);
                    w_state       = SEQ_SEND;
                end
            end
            SEQ_SEND: begin
                if (w_frame_done) begin
                    w_state   = SEQ_GAP;
                    w_gap_cnt = '0;
                    if (r_ext)
                        w_ext = 1'b0;
                    else if (r_brk)
                        w_brk = 1'b0;
                    else
                        w_last = 1'b1;
                end
            end
            SEQ_GAP: begin
                if (r_gap_cnt == GAP_LAST) begin
                    if (r_last) begin
                        w_state = SEQ_IDLE;
                    end else begin
                        w_frame_start = 1'b1;
                        w_state       = SEQ_SEND;
                    end
                end else begin
                    w_gap_cnt = r_gap_cnt + 1'b1;
                end
            end
            default: w_state = SEQ_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= SEQ_IDLE;
            r_gap_cnt <= '0;
            r_code    <= '0;
            r_ext     <= 1'b0;
            r_brk     <= 1'b0;
            r_last    <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_gap_cnt <= w_gap_cnt;
            r_code    <= w_code;
            r_ext     <= w_ext;
            r_brk     <= w_brk;
            r_last    <= w_last;
        end
    end

    ps2_frame_tx #(
        .HALF_PERIOD (HALF_PERIOD),
        .GAP_HALVES  (GAP_HALVES)
    ) u_frame_tx (
        .clk        (clk),
        .rst        (rst),
        .start      (w_frame_start),
        .data_byte  (w_frame_byte),
`ifdef PS2_TX_INHIBIT_EN
        .ps2_clk_in (ps2_clk_in),
`endif
        .done       (w_frame_done),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data)
    );

endmodule
`default_nettype wire
